// File: rtl/nanosoc_imem_loader_pkg.sv
// Shared FSM state type and fixed AHB-Lite encodings for the IMEM boot loader.
package nanosoc_imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_ADDR    = 3'd2,
        ST_DATA    = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam logic [1:0] HTRANS_IDLE     = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ   = 2'b10;
    localparam logic [2:0] HSIZE_WORD      = 3'b010;
    localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;

endpackage

// File: rtl/nanosoc_imem_loader_packer.sv
// Little-endian byte-to-word packer: byte k of each group of four lands in word[8k+7:8k].
module nanosoc_imem_loader_packer (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        collect,
    input  logic        word_clear,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0] byte_cnt;
    logic       take;

    assign in_ready   = collect;
    assign take       = in_valid && in_ready;
    // Flags the cycle the fourth byte is accepted; the assembled word is readable the cycle after.
    assign word_valid = take && (byte_cnt == 2'd3);

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            byte_cnt <= 2'd0;
            word     <= 32'd0;
        end else if (word_clear) begin
            byte_cnt <= 2'd0;
            word     <= 32'd0;
        end else if (take) begin
            // NOTE: non-blocking so the slice index uses the pre-increment byte count.
            word[{byte_cnt, 3'b000} +: 8] <= in_data;
            byte_cnt                      <= byte_cnt + 2'd1;
        end
    end

endmodule

// File: rtl/nanosoc_imem_loader.sv
// Boot-time AHB-Lite write master: streams bytes into IMEM as single, non-pipelined word writes.
module nanosoc_imem_loader
    import nanosoc_imem_loader_pkg::*;
#(
    parameter int                    SYS_ADDR_W      = 32,
    parameter int                    SYS_DATA_W      = 32,
    parameter int                    IMEM_RAM_ADDR_W = 14,
    parameter logic [SYS_ADDR_W-1:0] IMEM_BASE       = 32'h2000_0000
) (
    input  logic                       HCLK,
    input  logic                       HRESET,
    input  logic                       start,
    input  logic [IMEM_RAM_ADDR_W-2:0] word_count,
    input  logic                       s_valid,
    input  logic [7:0]                 s_data,
    output logic                       s_ready,
    output logic                       busy,
    output logic                       done,
    output logic                       error,
    output logic [SYS_ADDR_W-1:0]      HADDR,
    output logic [1:0]                 HTRANS,
    output logic [2:0]                 HSIZE,
    output logic                       HWRITE,
    output logic [3:0]                 HPROT,
    output logic [SYS_DATA_W-1:0]      HWDATA,
    input  logic                       HREADY,
    input  logic                       HRESP
);

    localparam int IDX_W = IMEM_RAM_ADDR_W - 2;
    localparam int CNT_W = IMEM_RAM_ADDR_W - 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = {1'b1, {IDX_W{1'b0}}};

    state_t                state;
    logic [IDX_W-1:0]      word_idx;
    logic [CNT_W-1:0]      remaining;
    logic [31:0]           packed_word;
    logic                  word_valid;
    logic                  word_clear;
    logic                  collect;
    logic [SYS_ADDR_W-1:0] word_addr;

    assign collect    = (state == ST_COLLECT);
    assign word_clear = (state == ST_IDLE) && start;
    assign word_addr  = IMEM_BASE + SYS_ADDR_W'({word_idx, 2'b00});
    assign HSIZE      = HSIZE_WORD;
    assign HPROT      = HPROT_DATA_PRIV;

    nanosoc_imem_loader_packer u_packer (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .collect    (collect),
        .word_clear (word_clear),
        .in_valid   (s_valid),
        .in_data    (s_data),
        .in_ready   (s_ready),
        .word_valid (word_valid),
        .word       (packed_word)
    );

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state     <= ST_IDLE;
            word_idx  <= '0;
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            HTRANS    <= HTRANS_IDLE;
            HADDR     <= IMEM_BASE;
            HWRITE    <= 1'b0;
            HWDATA    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        remaining <= (word_count == '0) ? FULL_COUNT : word_count;
                        word_idx  <= '0;
                        error     <= 1'b0;
                        busy      <= 1'b1;
                        state     <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (word_valid) begin
                        HTRANS <= HTRANS_NONSEQ;
                        HWRITE <= 1'b1;
                        HADDR  <= word_addr;
                        state  <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    // Address and control are held until the slave accepts the address phase.
                    if (HREADY) begin
                        HTRANS <= HTRANS_IDLE;
                        HWRITE <= 1'b0;
                        HWDATA <= SYS_DATA_W'(packed_word);
                        state  <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (HRESP) begin
                        // Two-cycle error response: flag on the first cycle, abort on the second.
                        error <= 1'b1;
                        if (HREADY) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end
                    end else if (HREADY) begin
                        word_idx  <= word_idx + 1'b1;
                        remaining <= remaining - 1'b1;
                        if (remaining == CNT_W'(1)) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            state <= ST_COLLECT;
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
